// File: rtl/block_scale_estimator.sv
// block_scale_estimator
// Collects BLOCK_SIZE signed samples, tracks the peak magnitude M, then derives
// a block scaling factor q = ceil(M / MAX_QUANTIZATION_VALUE) with a serial
// restoring divider. The factor is clamped to MAX_SCALING_FACTOR_VALUE and is
// never zero.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_data/in_valid  signed sample stream; in_ready high while accumulating
//   sf_data           scaling factor for the finished block
//   sf_max_abs        peak magnitude of the finished block
//   sf_sat            scaling factor was clamped
//   sf_valid/sf_ready result handshake
module block_scale_estimator #(
  parameter int INPUT_DATA_BITWIDTH      = 32,
  parameter int SCALING_FACTOR_BITWIDTH  = 12,
  parameter int BLOCK_SIZE               = 1024,
  parameter int MAX_QUANTIZATION_VALUE   = 2047,
  parameter int MAX_SCALING_FACTOR_VALUE = 4095
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [INPUT_DATA_BITWIDTH-1:0]     in_data,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [SCALING_FACTOR_BITWIDTH-1:0] sf_data,
  output logic [INPUT_DATA_BITWIDTH-1:0]     sf_max_abs,
  output logic                               sf_sat,
  output logic                               sf_valid,
  input  logic                               sf_ready
);
  localparam int W   = INPUT_DATA_BITWIDTH;
  localparam int SFW = SCALING_FACTOR_BITWIDTH;
  localparam int CW  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int DCW = $clog2(W + 2);

  localparam logic [W:0]     DIVISOR  = (W+1)'(MAX_QUANTIZATION_VALUE);
  localparam logic [W:0]     BIAS     = (W+1)'(MAX_QUANTIZATION_VALUE - 1);
  localparam logic [W:0]     SF_LIMIT = (W+1)'(MAX_SCALING_FACTOR_VALUE);
  localparam logic [CW-1:0]  LAST_IDX = CW'(BLOCK_SIZE - 1);
  localparam logic [DCW-1:0] DIV_END  = DCW'(W + 1);

  typedef enum logic [1:0] {ACCUM, DIV, OUT} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   peak, mag, peak_new;
  logic [W:0]     num, quo, rem_shift;
  logic [W-1:0]   rem, rem_next;
  logic [DCW-1:0] div_cnt;
  logic           accept, last, div_done, ge;

  assign in_ready = (state == ACCUM);
  assign sf_valid = (state == OUT);
  assign accept   = in_valid && in_ready;
  assign last     = (cnt == LAST_IDX);
  assign div_done = (div_cnt == DIV_END);

  // Two's-complement magnitude; the most negative value maps to 2^(W-1),
  // which still fits the unsigned W-bit peak register.
  always_comb begin
    mag      = in_data[W-1] ? (~in_data + 1'b1) : in_data;
    peak_new = ((cnt == '0) || (mag > peak)) ? mag : peak;
  end

  // Restoring step: the remainder stays below the divisor, so W bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    rem_shift = {rem, num[W]};
    ge        = (rem_shift >= DIVISOR);
    rem_next  = ge ? W'(rem_shift - DIVISOR) : rem_shift[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (accept && last) state_next = DIV;
      DIV:     if (div_done)       state_next = OUT;
      OUT:     if (sf_ready)       state_next = ACCUM;
      default:                     state_next = ACCUM;
    endcase
  end

  // DIV runs W+1 quotient steps followed by one result-formatting cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      peak       <= '0;
      num        <= '0;
      rem        <= '0;
      quo        <= '0;
      div_cnt    <= '0;
      sf_data    <= '0;
      sf_max_abs <= '0;
      sf_sat     <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            peak <= peak_new;
            cnt  <= last ? '0 : cnt + 1'b1;
            if (last) begin
              num     <= {1'b0, peak_new} + BIAS;
              rem     <= '0;
              quo     <= '0;
              div_cnt <= '0;
            end
          end
        end
        DIV: begin
          if (!div_done) begin
            rem     <= rem_next;
            quo     <= {quo[W-1:0], ge};
            num     <= {num[W-1:0], 1'b0};
            div_cnt <= div_cnt + 1'b1;
          end else begin
            sf_max_abs <= peak;
            if (peak == '0) begin
              sf_data <= SFW'(1);
              sf_sat  <= 1'b0;
            end else if (quo > SF_LIMIT) begin
              sf_data <= SFW'(MAX_SCALING_FACTOR_VALUE);
              sf_sat  <= 1'b1;
            end else begin
              sf_data <= quo[SFW-1:0];
              sf_sat  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
